multicycle_control: RTL and testbench

//  Main control FSM for the multicycle RISC-V core; sits directly upstream of ALUControl.

---
 rtl/multicycle_control.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//
// Main control FSM for the multicycle RISC-V core. It steps each instruction
// through fetch, decode, execute, memory and writeback. It drives the ALU
// operation class consumed by ALUControl and every datapath enable and select.
// The core uses one unified instruction/data memory, and each access completes
// when mem_ready is high. A watchdog bounds how long the FSM waits on memory.
//
// Optional feature macro: ITYPE_EN
//   defined   -> opcode 0010011 (OP-IMM) executes via EXECI then ALUWB
//   undefined -> opcode 0010011 is reported as illegal and EXECI is unreachable
//
// Parameters
//   TIMEOUT      max cycles spent waiting for mem_ready in FETCH/MEMREAD/MEMWRITE
//                (0 disables the watchdog)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   opcode       instr[6:0] from the instruction register
//   zero         ALU zero flag (branch decision)
//   mem_ready    memory access completes this cycle
//   pc_write     PC register enable
//   adr_src      memory address select: 0 PC, 1 ALUOut
//   ir_write     instruction register + oldPC enable
//   mem_write    memory write strobe
//   reg_write    register file write enable
//   result_src   00 ALUOut, 01 memory data, 10 ALU result
//   alu_src_a    00 PC, 01 oldPC, 10 rs1
//   alu_src_b    00 rs2, 01 immediate, 10 constant 4
//   alu_op       00 add, 01 sub/branch, 10 funct decode
//   illegal_op   one-cycle pulse on an unsupported opcode in DECODE
//   mem_timeout  one-cycle pulse when the memory watchdog expires
//   state_o      current state encoding (debug)

module multicycle_control #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        BEQ      = 4'd8,
        EXECI    = 4'd9
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;

`ifdef ITYPE_EN
    localparam bit ITYPE_ON = 1'b1;
`else
    localparam bit ITYPE_ON = 1'b0;
`endif

    // The counter only has to reach TIMEOUT-1, so it needs clog2(TIMEOUT) bits.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   wd_count;
    logic [CW-1:0]   wd_count_next;
    logic            wait_state;
    logic            expired;

    // State register and watchdog counter. Reset forces FETCH immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            wd_count <= '0;
        end else begin
            state    <= state_next;
            wd_count <= wd_count_next;
        end
    end

    // The watchdog expires on the last allowed wait cycle, and only if memory is
    // still not ready. A mem_ready in that same cycle lets the access complete.
    always_comb begin
        wait_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
        expired    = (TIMEOUT > 0) && wait_state && !mem_ready && (wd_count == WD_LAST);
    end

    // The count restarts whenever a wait state is entered. Leaving a state counts
    // as entry, and so does retrying FETCH after an expiry. Otherwise the count
    // advances once per idle memory cycle.
    always_comb begin
        wd_count_next = wd_count;
        if ((state_next != state) || expired) begin
            wd_count_next = '0;
        end else if (wait_state && !mem_ready) begin
            wd_count_next = wd_count + 1'b1;
        end
    end

    // Next-state logic and Moore output decode. When the watchdog fires, every
    // strobe stays low and the FSM returns to FETCH. The PC is left untouched,
    // so the same instruction is fetched again.
    always_comb begin
        state_next  = state;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;

        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end else if (expired) begin
                    mem_timeout = 1'b1;
                    state_next  = FETCH;
                end
            end
            DECODE: begin
                // oldPC + imm is precomputed here so BEQ can load it as the target
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_BEQ:       state_next = BEQ;
                    OP_I: begin
                        if (ITYPE_ON) begin
                            state_next = EXECI;
                        end else begin
                            illegal_op = 1'b1;
                            state_next = FETCH;
                        end
                    end
                    default: begin
                        illegal_op = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_next = MEMWB;
                end else if (expired) begin
                    mem_timeout = 1'b1;
                    state_next  = FETCH;
                end
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    mem_write  = 1'b1;
                    state_next = FETCH;
                end else if (expired) begin
                    mem_timeout = 1'b1;
                    state_next  = FETCH;
                end else begin
                    mem_write = 1'b1;
                end
            end
            EXECR: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_write   = zero;
                state_next = FETCH;
            end
            EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = ALUWB;
            end
            default: state_next = FETCH;
        endcase

        // During reset the state is already FETCH through the async clear. The
        // strobes still need gating here, because FETCH decodes them from mem_ready.
        if (!rst_n) begin
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            illegal_op  = 1'b0;
            mem_timeout = 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//
// Self-checking bench for multicycle_control. For each instruction the bench
// builds the expected per-cycle state trace from the instruction class and
// from the number of memory wait cycles chosen for it. It then drives
// mem_ready to match that trace and compares state_o and all control outputs
// every cycle. The expected outputs come from a per-state table of control
// values. Build with +define+ITYPE_EN to exercise the OP-IMM path.

module tb_multicycle_control;

    localparam int TIMEOUT = 16;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    // Expected trace of the instruction currently being run
    int st_q[$];
    bit rdy_q[$];
    bit to_q[$];

    multicycle_control #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .state_o     (state_o)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isLegal(input logic [6:0] o);
`ifdef ITYPE_EN
        return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_BEQ) || (o == OP_I);
`else
        return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_BEQ);
`endif
    endfunction

    // Per-state control table. The result is packed as
    // {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
    //  alu_src_a, alu_src_b, alu_op, illegal_op, mem_timeout}.
    function automatic logic [14:0] expOuts(input int s, input bit rdy, input bit z,
                                            input bit ill, input bit to);
        logic pc, adr, ir, mw, rw, il, tmo;
        logic [1:0] rs, a, b, op;
        {pc, adr, ir, mw, rw, il, tmo} = '0;
        {rs, a, b, op} = '0;
        case (s)
            0: begin b = 2'b10; rs = 2'b10; ir = rdy; pc = rdy; tmo = to; end
            1: begin a = 2'b01; b = 2'b01; il = ill; end
            2: begin a = 2'b10; b = 2'b01; end
            3: begin adr = 1'b1; tmo = to; end
            4: begin rs = 2'b01; rw = 1'b1; end
            5: begin adr = 1'b1; mw = !to; tmo = to; end
            6: begin a = 2'b10; op = 2'b10; end
            7: begin rw = 1'b1; end
            8: begin a = 2'b10; op = 2'b01; pc = z; end
            9: begin a = 2'b10; b = 2'b01; end
            default: ;
        endcase
        return {pc, adr, ir, mw, rw, rs, a, b, op, il, tmo};
    endfunction

    function automatic logic [14:0] obsOuts();
        return {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_op, illegal_op, mem_timeout};
    endfunction

    // One comparison: counted, and on mismatch reported with both values
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare one cycle at the falling edge, then advance just past the next rising edge
    task automatic cycleCheck(input string tag, input int s, input logic [14:0] e);
        @(negedge clk);
        checkOutput({tag, "_state"}, 32'(state_o), 32'(s));
        checkOutput({tag, "_outs"}, 32'(obsOuts()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    // Add a memory wait run to the trace. The run has w idle cycles and then
    // a ready cycle. If w reaches TIMEOUT, the run is instead TIMEOUT idle
    // cycles, and the last of them is the expiry cycle.
    task automatic addWait(input int s, input int w);
        if (w >= TIMEOUT) begin
            for (int i = 0; i < TIMEOUT; i++) begin
                st_q.push_back(s);
                rdy_q.push_back(1'b0);
                to_q.push_back(i == TIMEOUT - 1);
            end
        end else begin
            for (int i = 0; i <= w; i++) begin
                st_q.push_back(s);
                rdy_q.push_back(i == w);
                to_q.push_back(1'b0);
            end
        end
    endtask

    task automatic addState(input int s);
        st_q.push_back(s);
        rdy_q.push_back($urandom_range(0, 1) == 1);
        to_q.push_back(1'b0);
    endtask

    // Run one instruction of class kind (0 lw, 1 sw, 2 R, 3 beq, 4 I-type, 5 illegal).
    // wf and wm are the fetch and data memory waits, and zb is the zero flag seen in BEQ.
    task automatic applyStimulus(input int kind, input int wf, input int wm, input bit zb);
        logic [6:0] opc;
        bit         ill;
        case (kind)
            0: opc = OP_LW;
            1: opc = OP_SW;
            2: opc = OP_R;
            3: opc = OP_BEQ;
            4: opc = OP_I;
            default: begin
                opc = 7'($urandom);
                while (isLegal(opc) || opc == OP_I) opc = 7'($urandom);
            end
        endcase
        ill = !isLegal(opc);

        st_q.delete();
        rdy_q.delete();
        to_q.delete();
        addWait(0, wf);
        if (wf >= TIMEOUT) addWait(0, 0);
        addState(1);
        case (kind)
            0: begin
                addState(2);
                addWait(3, wm);
                if (wm < TIMEOUT) addState(4);
            end
            1: begin
                addState(2);
                addWait(5, wm);
            end
            2: begin addState(6); addState(7); end
            3: addState(8);
            4: begin
`ifdef ITYPE_EN
                addState(9);
                addState(7);
`endif
            end
            default: ;
        endcase

        for (int i = 0; i < st_q.size(); i++) begin
            bit zi;
            zi        = (st_q[i] == 8) ? zb : 1'($urandom);
            mem_ready = rdy_q[i];
            zero      = zi;
            // opcode is only meaningful in DECODE/MEMADR; scramble it elsewhere
            opcode    = (st_q[i] == 1 || st_q[i] == 2) ? opc : 7'($urandom);
            cycleCheck($sformatf("k%0d_c%0d", kind, i), st_q[i],
                       expOuts(st_q[i], rdy_q[i], zi, ill, to_q[i]));
        end
    endtask

    // Directed scenarios first, then a randomized instruction stream
    initial begin
        rst_n     = 1'b0;
        opcode    = 7'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #2;
        checkOutput("reset_state", 32'(state_o), 32'd0);
        checkOutput("reset_outs", 32'(obsOuts()), 32'(expOuts(0, 1'b0, 1'b0, 1'b0, 1'b0)));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // R-type, no waits
        applyStimulus(2, 0, 0, 1'b0);
        // lw with three idle cycles in MEMREAD
        applyStimulus(0, 0, 3, 1'b0);
        // beq taken, then not taken
        applyStimulus(3, 0, 0, 1'b1);
        applyStimulus(3, 0, 0, 1'b0);
        // sw with zero wait, then with memory never ready (watchdog)
        applyStimulus(1, 0, 0, 1'b0);
        applyStimulus(1, 0, TIMEOUT, 1'b0);
        // lw that expires in MEMREAD; a FETCH expiry and retry
        applyStimulus(0, 0, TIMEOUT, 1'b0);
        applyStimulus(2, TIMEOUT, 0, 1'b0);
        // ready arriving on the last allowed wait cycle must not expire
        applyStimulus(0, TIMEOUT - 1, TIMEOUT - 1, 1'b0);
        // OP-IMM and a plain illegal opcode
        applyStimulus(4, 0, 0, 1'b0);
        applyStimulus(5, 1, 0, 1'b0);

        // Reset asserted in the middle of a MEMREAD wait
        opcode    = OP_LW;
        mem_ready = 1'b1;
        cycleCheck("rst_f", 0, expOuts(0, 1'b1, 1'b0, 1'b0, 1'b0));
        cycleCheck("rst_d", 1, expOuts(1, 1'b0, 1'b0, 1'b0, 1'b0));
        cycleCheck("rst_a", 2, expOuts(2, 1'b0, 1'b0, 1'b0, 1'b0));
        mem_ready = 1'b0;
        cycleCheck("rst_r", 3, expOuts(3, 1'b0, 1'b0, 1'b0, 1'b0));
        #2;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        checkOutput("midrst_state", 32'(state_o), 32'd0);
        checkOutput("midrst_outs", 32'(obsOuts()), 32'(expOuts(0, 1'b0, 1'b0, 1'b0, 1'b0)));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycleCheck("rel_f", 0, expOuts(0, 1'b1, 1'b0, 1'b0, 1'b0));
        // Return to a clean FETCH before the random stream
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random instruction mix with random waits, including the TIMEOUT-1 boundary
        for (int n = 0; n < 150; n++) begin
            int k, wf, wm, r;
            k  = $urandom_range(0, 5);
            r  = $urandom_range(0, 5);
            wf = (r == 5) ? TIMEOUT - 1 : ((r == 4) ? TIMEOUT : r);
            r  = $urandom_range(0, 5);
            wm = (r == 5) ? TIMEOUT - 1 : ((r == 4) ? TIMEOUT : r);
            applyStimulus(k, wf, wm, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
